// File: rtl/bus_arbiter_rr_if.sv
// Shared-bus bundle between the two requesting masters and the round-robin arbiter.
// The master modport is the requester side; the slave modport is the arbiter side.
interface bus_arbiter_rr_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              m0_req;
  logic              m0_wr;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_dout;
  logic              m1_req;
  logic              m1_wr;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_dout;
  logic              m0_grant;
  logic              m1_grant;
  logic              s_valid;
  logic              s_wr;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_dout;

  modport master (
    output m0_req, m0_wr, m0_addr, m0_dout,
    output m1_req, m1_wr, m1_addr, m1_dout,
    input  m0_grant, m1_grant, s_valid, s_wr, s_addr, s_dout
  );

  modport slave (
    input  m0_req, m0_wr, m0_addr, m0_dout,
    input  m1_req, m1_wr, m1_addr, m1_dout,
    output m0_grant, m1_grant, s_valid, s_wr, s_addr, s_dout
  );
endinterface

// File: rtl/bus_arbiter_rr.sv
// Two-master round-robin bus arbiter with a tenure limit; forwards the owner's
// address, write enable and write data to the downstream address decoder.
//
// state | meaning
// IDLE  | no master owns the bus, shared bus driven to zero
// GNT0  | master 0 owns the bus
// GNT1  | master 1 owns the bus
module bus_arbiter_rr #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset,
  bus_arbiter_rr_if.slave   bus
);

  localparam int CNT_W = $clog2(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
  logic             last_owner, last_owner_nxt;

  logic              wr_sel;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] dout_sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      last_owner <= 1'b1;
    end else begin
      state      <= state_nxt;
      hold_cnt   <= hold_cnt_nxt;
      last_owner <= last_owner_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    hold_cnt_nxt   = '0;
    last_owner_nxt = last_owner;
    unique case (state)
      IDLE: begin
        if (bus.m0_req && bus.m1_req) state_nxt = last_owner ? GNT0 : GNT1;
        else if (bus.m0_req)          state_nxt = GNT0;
        else if (bus.m1_req)          state_nxt = GNT1;
      end
      GNT0: begin
        if (bus.m0_req) begin
          if (hold_cnt != HOLD_LAST) hold_cnt_nxt = hold_cnt + 1'b1;
          else if (bus.m1_req)       state_nxt    = GNT1;
          else                       hold_cnt_nxt = hold_cnt;
        end else begin
          state_nxt = bus.m1_req ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (bus.m1_req) begin
          if (hold_cnt != HOLD_LAST) hold_cnt_nxt = hold_cnt + 1'b1;
          else if (bus.m0_req)       state_nxt    = GNT0;
          else                       hold_cnt_nxt = hold_cnt;
        end else begin
          state_nxt = bus.m0_req ? GNT0 : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Staying in a grant state rewrites the same owner, so this covers every entry.
    if (state_nxt == GNT0)      last_owner_nxt = 1'b0;
    else if (state_nxt == GNT1) last_owner_nxt = 1'b1;
  end

  // Ungranted masters never reach the bus, including their write enable.
  always_comb begin
    wr_sel   = 1'b0;
    addr_sel = '0;
    dout_sel = '0;
    if (state == GNT0) begin
      wr_sel   = bus.m0_wr;
      addr_sel = bus.m0_addr;
      dout_sel = bus.m0_dout;
    end else if (state == GNT1) begin
      wr_sel   = bus.m1_wr;
      addr_sel = bus.m1_addr;
      dout_sel = bus.m1_dout;
    end
  end

  assign bus.m0_grant = (state == GNT0);
  assign bus.m1_grant = (state == GNT1);
  assign bus.s_valid  = (state == GNT0) || (state == GNT1);
  assign bus.s_wr     = wr_sel;
  assign bus.s_addr   = addr_sel;
  assign bus.s_dout   = dout_sel;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr: reset, single grants, ties, tenure preemption,
// saturation of the hold counter and reset in mid-tenure.
module tb_bus_arbiter_rr;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  bus_arbiter_rr_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  bus_arbiter_rr #(.ADDR_W(8), .DATA_W(32), .MAX_HOLD(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("onehot", 64'(bus.m0_grant & bus.m1_grant), 64'd0);
  endtask

  task automatic chk_grants(input string tag, input logic g0, input logic g1);
    chk({tag, "_g0"}, 64'(bus.m0_grant), 64'(g0));
    chk({tag, "_g1"}, 64'(bus.m1_grant), 64'(g1));
    chk({tag, "_valid"}, 64'(bus.s_valid), 64'(g0 | g1));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    bus.m0_req = 1'b1; bus.m0_wr = 1'b0; bus.m0_addr = '0; bus.m0_dout = '0;
    bus.m1_req = 1'b1; bus.m1_wr = 1'b0; bus.m1_addr = '0; bus.m1_dout = '0;

    // 1: reset held with both masters requesting
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_grants("rst", 1'b0, 1'b0);
      chk("rst_addr", 64'(bus.s_addr), 64'd0);
    end
    bus.m0_req = 1'b0; bus.m1_req = 1'b0;
    reset = 1'b0;
    tick();
    chk_grants("idle", 1'b0, 1'b0);

    // 2: single master 0 write
    bus.m0_req = 1'b1; bus.m0_addr = 8'h0F; bus.m0_wr = 1'b1; bus.m0_dout = 32'hA5A5A5A5;
    bus.m1_wr = 1'b1; bus.m1_addr = 8'h2A; bus.m1_dout = 32'h12345678;
    #1;
    chk_grants("req0_lat", 1'b0, 1'b0);
    tick();
    chk_grants("gnt0", 1'b1, 1'b0);
    chk("gnt0_addr", 64'(bus.s_addr), 64'h0F);
    chk("gnt0_wr",   64'(bus.s_wr),   64'd1);
    chk("gnt0_dout", 64'(bus.s_dout), 64'hA5A5A5A5);
    bus.m0_wr = 1'b0;
    #1;
    chk("wr_qual", 64'(bus.s_wr), 64'd0);
    bus.m0_req = 1'b0;
    tick();
    chk_grants("drop0", 1'b0, 1'b0);
    chk("idle_wr",   64'(bus.s_wr),   64'd0);
    chk("idle_addr", 64'(bus.s_addr), 64'd0);
    chk("idle_dout", 64'(bus.s_dout), 64'd0);
    bus.m1_wr = 1'b0;

    // 3: first tie after reset goes to m0, then handoff with no gap
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    bus.m0_req = 1'b1; bus.m1_req = 1'b1;
    tick();
    chk_grants("tie_first", 1'b1, 1'b0);
    bus.m0_req = 1'b0;
    tick();
    chk_grants("handoff", 1'b0, 1'b1);
    chk("handoff_addr", 64'(bus.s_addr), 64'h2A);

    // 4: continuous contention alternates every 4 cycles
    bus.m1_req = 1'b0;
    tick();
    chk_grants("idle4", 1'b0, 1'b0);
    bus.m0_req = 1'b1; bus.m1_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk_grants($sformatf("rr%0d", i), ((i / 4) % 2) == 0, ((i / 4) % 2) == 1);
    end

    // 5: lone master 1 keeps the bus, hold counter saturates
    bus.m0_req = 1'b0; bus.m1_req = 1'b0;
    tick();
    chk_grants("idle5", 1'b0, 1'b0);
    bus.m1_req = 1'b1; bus.m1_addr = 8'h2F;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_grants($sformatf("solo%0d", i), 1'b0, 1'b1);
      chk($sformatf("solo%0d_addr", i), 64'(bus.s_addr), 64'h2F);
    end
    chk("hold_sat", 64'(dut.hold_cnt), 64'd3);

    // 6: reset in cycle 2 of an m1 tenure
    bus.m1_req = 1'b0;
    tick();
    chk_grants("idle6", 1'b0, 1'b0);
    bus.m1_req = 1'b1;
    tick();
    tick();
    chk_grants("mid_tenure", 1'b0, 1'b1);
    reset = 1'b1;
    bus.m0_req = 1'b1;
    tick();
    chk_grants("mid_reset", 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    chk_grants("post_tie", 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
